// File: rtl/btb_predictor_pkg.sv
// rtl/btb_predictor_pkg.sv - shared constants and PC slicing helpers for the BTB
package btb_predictor_pkg;

  localparam int PC_WIDTH_DEFAULT = 32;

  // Index field starts above the always-zero instruction alignment bits
  localparam int IDX_LSB = 2;

  function automatic int tag_lsb(input int idx_bits);
    return IDX_LSB + idx_bits;
  endfunction

  function automatic int ctr_weak_taken(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int ctr_strong_taken(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// rtl/btb_predictor_sat_counter.sv - saturating up/down counter next-value logic
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (up) begin
      if (cur != '1) nxt = cur + 1'b1;
    end else begin
      if (cur != '0) nxt = cur - 1'b1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - branch target buffer with per-entry direction counters
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEFAULT,
  parameter int ENTRIES   = 16,
  parameter int TAG_WIDTH = 8,
  parameter int CTR_WIDTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PC_WIDTH-1:0]  F_PC_i,
  output logic                 pred_taken_o,
  output logic [PC_WIDTH-1:0]  pred_target_o,
  input  logic                 flush_i,
  input  logic                 upd_valid_i,
  input  logic [PC_WIDTH-1:0]  upd_PC_i,
  input  logic                 upd_is_jump_i,
  input  logic                 upd_taken_i,
  input  logic [PC_WIDTH-1:0]  upd_target_i,
  input  logic                 upd_pred_taken_i,
  input  logic [PC_WIDTH-1:0]  upd_pred_target_i,
  output logic [CNT_WIDTH-1:0] mispred_cnt_o
);

  localparam int IDX     = $clog2(ENTRIES);
  localparam int TAG_LSB = tag_lsb(IDX);
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK   = CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] CTR_STRONG = CTR_WIDTH'(ctr_strong_taken(CTR_WIDTH));

  logic                 valid_q  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_q    [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_step [ENTRIES];
  logic [CNT_WIDTH-1:0] mispred_q;

  logic [IDX-1:0]       f_idx, u_idx;
  logic [TAG_WIDTH-1:0] f_tag, u_tag;
  logic                 f_hit, u_hit, mispred;
  logic                 unused_pc_bits;

  assign f_idx = F_PC_i[TAG_LSB-1:IDX_LSB];
  assign f_tag = F_PC_i[TAG_LSB+TAG_WIDTH-1:TAG_LSB];
  assign u_idx = upd_PC_i[TAG_LSB-1:IDX_LSB];
  assign u_tag = upd_PC_i[TAG_LSB+TAG_WIDTH-1:TAG_LSB];
  assign unused_pc_bits = ^{F_PC_i, upd_PC_i};

  // Lookup reads registered state only, so a same-cycle update is not forwarded
  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken_o  = f_hit && ctr_q[f_idx][CTR_WIDTH-1];
  assign pred_target_o = pred_taken_o ? target_q[f_idx] : '0;

  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign mispred = upd_valid_i &&
                   ((upd_taken_i != upd_pred_taken_i) ||
                    (upd_taken_i && upd_pred_taken_i && (upd_target_i != upd_pred_target_i)));

  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    sat_counter #(.WIDTH(CTR_WIDTH)) u_ctr (
      .cur (ctr_q[e]),
      .up  (upd_taken_i),
      .nxt (ctr_step[e])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      mispred_q <= '0;
    end else begin
      if (mispred) mispred_q <= mispred_q + 1'b1;
      if (flush_i) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (upd_valid_i) begin
        if (u_hit) begin
          if (upd_is_jump_i) begin
            ctr_q[u_idx]    <= CTR_STRONG;
            target_q[u_idx] <= upd_target_i;
          end else begin
            ctr_q[u_idx] <= ctr_step[u_idx];
            if (upd_taken_i) target_q[u_idx] <= upd_target_i;
          end
        end else if (upd_taken_i) begin
          // A taken miss evicts whatever aliased into this index
          valid_q[u_idx]  <= 1'b1;
          tag_q[u_idx]    <= u_tag;
          target_q[u_idx] <= upd_target_i;
          ctr_q[u_idx]    <= upd_is_jump_i ? CTR_STRONG : CTR_WEAK;
        end
      end
    end
  end

  assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - self-checking bench for btb_predictor against a table model
module tb_btb_predictor;

  localparam int PW = 32;
  localparam int EN = 16;
  localparam int TW = 8;
  localparam int CW = 2;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, upd_valid_i, upd_is_jump_i, upd_taken_i, upd_pred_taken_i;
  logic [PW-1:0] F_PC_i, upd_PC_i, upd_target_i, upd_pred_target_i, pred_target_o;
  logic          pred_taken_o;
  logic [NW-1:0] mispred_cnt_o;

  always #5 clk = ~clk;

  btb_predictor #(.PC_WIDTH(PW), .ENTRIES(EN), .TAG_WIDTH(TW), .CTR_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk_i(clk), .rst_i(rst_i), .F_PC_i(F_PC_i), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .flush_i(flush_i), .upd_valid_i(upd_valid_i),
    .upd_PC_i(upd_PC_i), .upd_is_jump_i(upd_is_jump_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .mispred_cnt_o(mispred_cnt_o)
  );

  // Behavioural model: one record per slot, counter as a plain integer 0..3
  bit          m_valid  [EN];
  int unsigned m_tag    [EN];
  logic [31:0] m_target [EN];
  int          m_ctr    [EN];
  int unsigned m_cnt;
  int n_checks = 0;
  int n_errors = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % EN);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * EN)) % (1 << TW);
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pt(pc) ? m_target[idx_of(pc)] : 32'h0;
  endfunction

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < EN; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input bit uv, input logic [31:0] pc, input bit jmp, input bit tk,
                            input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                            input bit fl, input bit rs);
    int i = idx_of(pc);
    bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (rs) begin
      model_reset();
      return;
    end
    if (uv && ((tk != ptk) || (tk && tgt != ptgt))) m_cnt++;
    if (fl) begin
      for (int k = 0; k < EN; k++) m_valid[k] = 0;
    end else if (uv) begin
      if (hit && jmp) begin
        m_ctr[i] = 3; m_target[i] = tgt;
      end else if (hit) begin
        m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (tk) m_target[i] = tgt;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_ctr[i] = jmp ? 3 : 2;
      end
    end
  endtask

  task automatic look(input string nm, input logic [31:0] pc);
    upd_valid_i = 0; flush_i = 0; F_PC_i = pc;
    #1;
    check({nm, "_taken"}, 64'(pred_taken_o), 64'(m_pt(pc)));
    check({nm, "_target"}, 64'(pred_target_o), 64'(m_ptgt(pc)));
  endtask

  // One clock: same-cycle lookup is checked against the pre-update model
  task automatic cyc(input logic [31:0] fpc, input bit uv, input logic [31:0] pc, input bit jmp,
                     input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                     input bit fl, input bit rs);
    F_PC_i = fpc; upd_valid_i = uv; upd_PC_i = pc; upd_is_jump_i = jmp; upd_taken_i = tk;
    upd_target_i = tgt; upd_pred_taken_i = ptk; upd_pred_target_i = ptgt; flush_i = fl; rst_i = rs;
    #1;
    if (!rs) begin
      check("cyc_taken", 64'(pred_taken_o), 64'(m_pt(fpc)));
      check("cyc_target", 64'(pred_target_o), 64'(m_ptgt(fpc)));
    end
    @(posedge clk);
    model_step(uv, pc, jmp, tk, tgt, ptk, ptgt, fl, rs);
    #1;
    rst_i = 0; flush_i = 0; upd_valid_i = 0;
    check("mispred_cnt", 64'(mispred_cnt_o), 64'(m_cnt));
  endtask

  initial begin
    logic [31:0] rpc, rtgt, rf;
    bit rjmp, rtk, rptk;

    rst_i = 1; flush_i = 0; upd_valid_i = 0; upd_PC_i = 0; upd_is_jump_i = 0; upd_taken_i = 0;
    upd_target_i = 0; upd_pred_taken_i = 0; upd_pred_target_i = 0; F_PC_i = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 0;
    model_reset();

    look("reset_0x100", 32'h100);
    check("reset_cnt", 64'(mispred_cnt_o), 64'd0);

    cyc(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h0, 0, 0);
    look("alloc_0x100", 32'h100);
    check("alloc_target_const", 64'(pred_target_o), 64'h80);
    check("alloc_cnt_const", 64'(mispred_cnt_o), 64'd1);
    cyc(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 32'h80, 0, 0);
    look("nt_0x100", 32'h100);
    check("nt_taken_const", 64'(pred_taken_o), 64'd0);
    check("nt_cnt_const", 64'(mispred_cnt_o), 64'd2);

    cyc(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h0, 0, 0);
    look("alias_miss_0x140", 32'h140);
    cyc(32'h140, 1, 32'h140, 0, 1, 32'h200, 0, 32'h0, 0, 0);
    look("alias_hit_0x140", 32'h140);
    look("alias_evict_0x100", 32'h100);
    check("alias_evict_const", 64'(pred_taken_o), 64'd0);

    cyc(32'h20, 1, 32'h20, 1, 1, 32'h400, 0, 32'h0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(32'h20, 1, 32'h20, 0, 1, 32'h400, 1, 32'h400, 0, 0);
    cyc(32'h20, 1, 32'h20, 0, 0, 32'h0, 1, 32'h400, 0, 0);
    look("jump_weak_0x20", 32'h20);
    check("jump_weak_const", 64'(pred_target_o), 64'h400);
    cyc(32'h20, 1, 32'h20, 0, 0, 32'h0, 1, 32'h400, 0, 0);
    look("jump_nt_0x20", 32'h20);

    cyc(32'h10, 1, 32'h10, 0, 1, 32'h1000, 0, 32'h0, 0, 0);
    cyc(32'h14, 1, 32'h14, 1, 1, 32'h1400, 0, 32'h0, 0, 0);
    cyc(32'h18, 1, 32'h18, 0, 1, 32'h1800, 0, 32'h0, 0, 0);
    look("fill_0x14", 32'h14);
    cyc(32'h18, 1, 32'h300, 0, 1, 32'h3000, 0, 32'h0, 1, 0);
    look("flush_0x10", 32'h10);
    look("flush_0x14", 32'h14);
    look("flush_0x18", 32'h18);
    look("flush_0x300", 32'h300);
    check("flush_0x300_const", 64'(pred_taken_o), 64'd0);

    cyc(32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    for (int k = 0; k < 5; k++)
      cyc(32'h40, 1, 32'h40 + 32'(k * 4), 0, 1, 32'h5000, 0, 32'h0, 0, 0);
    check("five_cnt_const", 64'(mispred_cnt_o), 64'd5);
    cyc(32'h40, 1, 32'h60, 1, 1, 32'h6000, 0, 32'h0, 0, 1);
    for (int k = 0; k < 6; k++) look("rst_miss", 32'h40 + 32'(k * 4));
    check("rst_cnt_const", 64'(mispred_cnt_o), 64'd0);

    for (int n = 0; n < 400; n++) begin
      rpc  = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      rf   = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      rtgt = 32'($urandom_range(1, 4)) << 8;
      rjmp = ($urandom_range(0, 3) == 0);
      rtk  = rjmp || ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 7) rptk = m_pt(rpc);
      else rptk = 1'($urandom_range(0, 1));
      cyc(rf, ($urandom_range(0, 4) != 0), rpc, rjmp, rtk, rtk ? rtgt : 32'h0,
          rptk, rptk ? m_ptgt(rpc) | (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0) : 32'h0,
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
